// File: rtl/scanline_scheduler.sv
// scanline_scheduler
// Per-scanline sequencer for the sprite pipeline (pixel-clock domain).
// Each visible line it starts prepare_line for the next line. Once the object
// list is ready it hands the OAM read port to sprite_drawer. At end of line it
// either swaps the two line buffers or kills an unfinished job and blanks the
// line.
// Optional feature macro: SCHED_OVERRUN_CNT_EN adds the saturating overrun
// counter. Without it, overrun_cnt is tied to zero.
module scanline_scheduler #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CORDW   = 10
) (
    input  logic             clk,
    input  logic             btn_rst,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             prep_done,
    input  logic             draw_done,
    output logic             prep_start,
    output logic [CORDW-1:0] prep_line,
    output logic             draw_start,
    output logic             oam_sel,
    output logic             buf_sel,
    output logic             buf_swap,
    output logic             line_valid,
    output logic             job_abort,
    output logic             busy,
    output logic [7:0]       overrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CORDW-1:0] ONE_C  = {{(CORDW-1){1'b0}}, 1'b1};
    localparam logic [CORDW-1:0] ZERO_C = {CORDW{1'b0}};

    state_t           state_r;
    logic             prep_start_r;
    logic [CORDW-1:0] prep_line_r;
    logic             draw_start_r;
    logic             oam_sel_r;
    logic             buf_sel_r;
    logic             buf_swap_r;
    logic             line_valid_r;
    logic             job_abort_r;
    logic             busy_r;

    logic [CORDW-1:0] target_s;
    logic             trigger_s;
    logic             eol_s;
    logic             swap_s;
    logic             abort_s;

    // The blanking interval must exist for the end-of-line handoff to make sense
    if (H_RES >= H_TOTAL || V_RES >= V_TOTAL) begin : g_bad_timing
        $error("scanline_scheduler: visible area must be smaller than total");
    end

    // Decode the line position and the end-of-line outcome of the current job
    always_comb begin
        if (sy == CORDW'(V_TOTAL - 1)) begin
            target_s = ZERO_C;
        end else begin
            target_s = sy + ONE_C;
        end
        eol_s     = (sx == CORDW'(H_TOTAL - 1));
        trigger_s = (sx == ZERO_C) && (target_s < CORDW'(V_RES));
        swap_s    = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            ST_PREP: begin
                swap_s  = 1'b0;
                abort_s = eol_s;
            end
            // A draw_done landing on the last pixel still counts as finished
            ST_DRAW: begin
                swap_s  = eol_s && draw_done;
                abort_s = eol_s && !draw_done;
            end
            ST_DONE: begin
                swap_s  = eol_s;
                abort_s = 1'b0;
            end
            default: begin
                swap_s  = 1'b0;
                abort_s = 1'b0;
            end
        endcase
    end

    // Job sequencer: state, control pulses and line-buffer bookkeeping
    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            state_r      <= ST_IDLE;
            prep_start_r <= 1'b0;
            prep_line_r  <= ZERO_C;
            draw_start_r <= 1'b0;
            oam_sel_r    <= 1'b0;
            buf_sel_r    <= 1'b0;
            buf_swap_r   <= 1'b0;
            line_valid_r <= 1'b0;
            job_abort_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            prep_start_r <= 1'b0;
            draw_start_r <= 1'b0;
            buf_swap_r   <= 1'b0;
            job_abort_r  <= 1'b0;
            if (swap_s) begin
                state_r      <= ST_IDLE;
                buf_sel_r    <= !buf_sel_r;
                buf_swap_r   <= 1'b1;
                line_valid_r <= 1'b1;
                oam_sel_r    <= 1'b0;
                busy_r       <= 1'b0;
            end else if (abort_s) begin
                state_r      <= ST_IDLE;
                job_abort_r  <= 1'b1;
                line_valid_r <= 1'b0;
                oam_sel_r    <= 1'b0;
                busy_r       <= 1'b0;
            end else if (eol_s) begin
                // Only IDLE reaches here: a line without a job displays nothing
                line_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (trigger_s) begin
                            state_r      <= ST_PREP;
                            prep_line_r  <= target_s;
                            prep_start_r <= 1'b1;
                            oam_sel_r    <= 1'b0;
                            busy_r       <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_PREP: begin
                        if (prep_done) begin
                            state_r      <= ST_DRAW;
                            draw_start_r <= 1'b1;
                            oam_sel_r    <= 1'b1;
                        end else begin
                            state_r <= ST_PREP;
                        end
                    end
                    ST_DRAW: begin
                        if (draw_done) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DRAW;
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

`ifdef SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_r;

    // Saturating tally of jobs killed at end of line
    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            overrun_cnt_r <= 8'd0;
        end else if (abort_s && (overrun_cnt_r != 8'hFF)) begin
            overrun_cnt_r <= overrun_cnt_r + 8'd1;
        end else begin
            overrun_cnt_r <= overrun_cnt_r;
        end
    end

    assign overrun_cnt = overrun_cnt_r;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign prep_start = prep_start_r;
    assign prep_line  = prep_line_r;
    assign draw_start = draw_start_r;
    assign oam_sel    = oam_sel_r;
    assign buf_sel    = buf_sel_r;
    assign buf_swap   = buf_swap_r;
    assign line_valid = line_valid_r;
    assign job_abort  = job_abort_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_scanline_scheduler.sv
// Testbench for scanline_scheduler.
// Lines are compressed: sx counts 0,1,2,... and then jumps to H_TOTAL-1 on the
// last cycle of the line. The scheduler only reacts to sx==0 and
// sx==H_TOTAL-1. Each line's outcome is predicted arithmetically from when the
// prep_done and draw_done levels rise.
module tb_scanline_scheduler;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int CORDW   = 10;
    localparam int NEVER   = 100000;

    logic             clk;
    logic             btn_rst;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             prep_done;
    logic             draw_done;
    logic             prep_start;
    logic [CORDW-1:0] prep_line;
    logic             draw_start;
    logic             oam_sel;
    logic             buf_sel;
    logic             buf_swap;
    logic             line_valid;
    logic             job_abort;
    logic             busy;
    logic [7:0]       overrun_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state kept at line granularity
    int m_buf_sel    = 0;
    int m_line_valid = 0;
    int m_cnt        = 0;
    int m_prep_line  = 0;

    scanline_scheduler #(
        .H_RES(H_RES), .V_RES(V_RES), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .CORDW(CORDW)
    ) dut (
        .clk(clk), .btn_rst(btn_rst), .sx(sx), .sy(sy),
        .prep_done(prep_done), .draw_done(draw_done),
        .prep_start(prep_start), .prep_line(prep_line), .draw_start(draw_start),
        .oam_sel(oam_sel), .buf_sel(buf_sel), .buf_swap(buf_swap),
        .line_valid(line_valid), .job_abort(job_abort), .busy(busy),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " prep_start"},  32'(prep_start),  32'd0);
        check_eq({tag, " prep_line"},   32'(prep_line),   32'd0);
        check_eq({tag, " draw_start"},  32'(draw_start),  32'd0);
        check_eq({tag, " oam_sel"},     32'(oam_sel),     32'd0);
        check_eq({tag, " buf_sel"},     32'(buf_sel),     32'd0);
        check_eq({tag, " buf_swap"},    32'(buf_swap),    32'd0);
        check_eq({tag, " line_valid"},  32'(line_valid),  32'd0);
        check_eq({tag, " job_abort"},   32'(job_abort),   32'd0);
        check_eq({tag, " busy"},        32'(busy),        32'd0);
        check_eq({tag, " overrun_cnt"}, 32'(overrun_cnt), 32'd0);
    endtask

    // One line of len cycles at row sy_v. prep_done rises at cycle p, draw_done at cycle d.
    // If rst_at >= 0, reset is pulled asynchronously in that cycle and the line is dropped.
    task automatic run_line(input int sy_v, input int len, input int p, input int d, input int rst_at);
        int  target;
        bit  trig;
        int  cp;
        int  cd;
        bit  pacc;
        bit  dacc;
        int  busy_end;
        string tg;
        target = (sy_v == V_TOTAL - 1) ? 0 : sy_v + 1;
        trig   = (target < V_RES);
        cp     = (p > 1) ? p : 1;
        pacc   = trig && (cp < len - 1);
        cd     = (d > cp + 1) ? d : cp + 1;
        dacc   = pacc && (cd <= len - 1);
        busy_end = dacc ? cd : len - 1;
        for (int c = 0; c < len; c++) begin
            sx        = (c == len - 1) ? CORDW'(H_TOTAL - 1) : CORDW'(c);
            sy        = CORDW'(sy_v);
            prep_done = (c >= p);
            draw_done = (c >= d);
            if (c == rst_at) begin
                #2 btn_rst = 1'b0;
                #1 check_reset_values($sformatf("async_rst sy=%0d c=%0d", sy_v, c));
                m_buf_sel = 0; m_line_valid = 0; m_cnt = 0; m_prep_line = 0;
                @(negedge clk);
                sx = CORDW'(5);
                @(negedge clk);
                btn_rst = 1'b1;
                @(negedge clk);
                check_reset_values("after_rst_release");
                return;
            end
            @(negedge clk);
            if (trig && c == 0) m_prep_line = target;
            if (c == len - 1) begin
                if (dacc) begin
                    m_buf_sel    = 1 - m_buf_sel;
                    m_line_valid = 1;
                end else begin
                    m_line_valid = 0;
                end
`ifdef SCHED_OVERRUN_CNT_EN
                if (trig && !dacc && m_cnt < 255) m_cnt++;
`endif
            end
            tg = $sformatf("sy=%0d c=%0d", sy_v, c);
            check_eq({tg, " prep_start"}, 32'(prep_start), 32'(trig && c == 0));
            check_eq({tg, " prep_line"},  32'(prep_line),  32'(m_prep_line));
            check_eq({tg, " draw_start"}, 32'(draw_start), 32'(pacc && c == cp));
            check_eq({tg, " oam_sel"},    32'(oam_sel),    32'(pacc && c >= cp && c < len - 1));
            check_eq({tg, " busy"},       32'(busy),       32'(trig && c < busy_end));
            check_eq({tg, " buf_swap"},   32'(buf_swap),   32'(c == len - 1 && dacc));
            check_eq({tg, " job_abort"},  32'(job_abort),  32'(c == len - 1 && trig && !dacc));
            check_eq({tg, " buf_sel"},    32'(buf_sel),    32'(m_buf_sel));
            check_eq({tg, " line_valid"}, 32'(line_valid), 32'(m_line_valid));
            check_eq({tg, " overrun_cnt"}, 32'(overrun_cnt), 32'(m_cnt));
        end
    endtask

    initial begin
        int len;
        btn_rst   = 1'b0;
        sx        = CORDW'(5);
        sy        = CORDW'(0);
        prep_done = 1'b0;
        draw_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        btn_rst = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset_idle");

        // Normal full-length line: prep_done 100 cycles after start, draw_done 300 after
        run_line(9, H_TOTAL, 101, 301, -1);
        check_eq("normal buf_sel", 32'(buf_sel), 32'd1);
        check_eq("normal prep_line", 32'(prep_line), 32'd10);

        // Blank lines never trigger, then the last line prepares line 0
        for (int y = V_RES - 1; y < V_TOTAL - 1; y++) run_line(y, 12, 2, 4, -1);
        check_eq("blank line_valid", 32'(line_valid), 32'd0);
        run_line(V_TOTAL - 1, 40, 3, 10, -1);
        check_eq("wrap prep_line", 32'(prep_line), 32'd0);
        check_eq("wrap line_valid", 32'(line_valid), 32'd1);

        // Overrun: draw_done withheld for 300 lines
        for (int i = 0; i < 300; i++) run_line($urandom_range(0, V_RES - 2), 8, 2, NEVER, -1);
`ifdef SCHED_OVERRUN_CNT_EN
        check_eq("overrun saturate", 32'(overrun_cnt), 32'd255);
`else
        check_eq("overrun tied off", 32'(overrun_cnt), 32'd0);
`endif

        // Race: draw_done arrives exactly on the last pixel
        run_line(100, 30, 4, 29, -1);
        check_eq("race line_valid", 32'(line_valid), 32'd1);

        // Reset while drawing, then a normal restart
        run_line(20, 100, 5, NEVER, 30);
        run_line(20, 60, 5, 20, -1);
        check_eq("restart buf_sel", 32'(buf_sel), 32'd1);

        // Randomized lines
        for (int i = 0; i < 200; i++) begin
            len = $urandom_range(4, 60);
            run_line($urandom_range(0, V_TOTAL - 1), len,
                     $urandom_range(0, len + 2), $urandom_range(0, len + 3), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
